// File: rtl/score_pkg.sv
// rtl/score_pkg.sv - opcodes and FSM state encoding shared by the score table controller
package score_pkg;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_DUMP  = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b10;
    localparam logic [1:0] OP_ADD   = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD_WAIT,
        RMW_WR,
        DUMP_RD,
        DUMP_OUT
    } state_e;

endpackage

// File: rtl/score_sat_add.sv
// rtl/score_sat_add.sv - score adder with overflow bit; SCORE_SAT_EN clamps on overflow
module score_sat_add #(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] sum_o,
    output logic              ovf_o
);
    logic [DATA_W:0] full_sum;

    assign full_sum = {1'b0, a_i} + {1'b0, b_i};
    assign ovf_o    = full_sum[DATA_W];

`ifdef SCORE_SAT_EN
    assign sum_o = ovf_o ? '1 : full_sum[DATA_W-1:0];
`else
    assign sum_o = full_sum[DATA_W-1:0];
`endif

endmodule

// File: rtl/score_table_ctrl.sv
// rtl/score_table_ctrl.sv - score table controller: write/add/dump over a fixed-latency RAM
// SCORE_SAT_EN: saturating ADD with sticky sat_flag; otherwise ADD wraps and sat_flag is 0
module score_table_ctrl
    import score_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 8,
    parameter int NUM_ENTRIES = 256,
    parameter int RD_LAT      = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_id,
    input  logic [DATA_W-1:0] cmd_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wren,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_id,
    output logic [DATA_W-1:0] out_score,
    output logic              out_last,
    output logic              busy,
    output logic              cmd_err,
    output logic              sat_flag
);
    localparam int                CNT_W   = $clog2(RD_LAT + 1);
    localparam logic [CNT_W-1:0]  CNT_END = CNT_W'(RD_LAT);
    localparam logic [ADDR_W-1:0] LAST_ID = ADDR_W'(NUM_ENTRIES - 1);
`ifdef SCORE_SAT_EN
    localparam logic SAT_EN = 1'b1;
`else
    localparam logic SAT_EN = 1'b0;
`endif

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wren_q, wren_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              err_q, err_d;
    logic              sat_q, sat_d;
    logic              ovalid_q, ovalid_d;
    logic [ADDR_W-1:0] oid_q, oid_d;
    logic [DATA_W-1:0] oscore_q, oscore_d;
    logic              olast_q, olast_d;

    logic              id_oob;
    logic              accept;
    logic [DATA_W-1:0] add_sum;
    logic              add_ovf;

    score_sat_add #(.DATA_W(DATA_W)) u_add (
        .a_i   (ram_rdata),
        .b_i   (data_q),
        .sum_o (add_sum),
        .ovf_o (add_ovf)
    );

    // Compared one bit wider so a full 2^ADDR_W table never flags an id as out of range
    assign id_oob = {1'b0, cmd_id} >= (ADDR_W + 1)'(NUM_ENTRIES);
    assign accept = cmd_valid && cmd_ready;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        addr_d   = addr_q;
        wren_d   = 1'b0;
        wdata_d  = wdata_q;
        err_d    = 1'b0;
        sat_d    = sat_q;
        ovalid_d = ovalid_q;
        oid_d    = oid_q;
        oscore_d = oscore_q;
        olast_d  = olast_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    data_d = cmd_data;
                    case (cmd_op)
                        OP_DUMP: begin
                            addr_d  = '0;
                            cnt_d   = '0;
                            state_d = DUMP_RD;
                        end
                        OP_WRITE: begin
                            if (id_oob) begin
                                err_d = 1'b1;
                            end else begin
                                addr_d  = cmd_id;
                                wdata_d = cmd_data;
                                wren_d  = 1'b1;
                                state_d = WR;
                            end
                        end
                        OP_ADD: begin
                            if (id_oob) begin
                                err_d = 1'b1;
                            end else begin
                                addr_d  = cmd_id;
                                cnt_d   = '0;
                                state_d = RD_WAIT;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            WR, RMW_WR: state_d = IDLE;
            RD_WAIT: begin
                if (cnt_q == CNT_END) begin
                    wdata_d = add_sum;
                    wren_d  = 1'b1;
                    sat_d   = sat_q | (SAT_EN & add_ovf);
                    state_d = RMW_WR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DUMP_RD: begin
                if (cnt_q == CNT_END) begin
                    oscore_d = ram_rdata;
                    oid_d    = addr_q;
                    olast_d  = (addr_q == LAST_ID);
                    ovalid_d = 1'b1;
                    state_d  = DUMP_OUT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DUMP_OUT: begin
                if (out_ready) begin
                    ovalid_d = 1'b0;
                    olast_d  = 1'b0;
                    if (olast_q) begin
                        state_d = IDLE;
                    end else begin
                        addr_d  = addr_q + ADDR_W'(1);
                        cnt_d   = '0;
                        state_d = DUMP_RD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            data_q   <= '0;
            addr_q   <= '0;
            wren_q   <= 1'b0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            sat_q    <= 1'b0;
            ovalid_q <= 1'b0;
            oid_q    <= '0;
            oscore_q <= '0;
            olast_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            addr_q   <= addr_d;
            wren_q   <= wren_d;
            wdata_q  <= wdata_d;
            err_q    <= err_d;
            sat_q    <= sat_d;
            ovalid_q <= ovalid_d;
            oid_q    <= oid_d;
            oscore_q <= oscore_d;
            olast_q  <= olast_d;
        end
    end

    // Gated by rst so cmd_ready reads 0 while reset is held
    assign cmd_ready = rst && (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign ram_addr  = addr_q;
    assign ram_wren  = wren_q;
    assign ram_wdata = wdata_q;
    assign out_valid = ovalid_q;
    assign out_id    = oid_q;
    assign out_score = oscore_q;
    assign out_last  = olast_q;
    assign cmd_err   = err_q;
    assign sat_flag  = sat_q;

endmodule

// File: tb/tb_score_table_ctrl.sv
// tb/tb_score_table_ctrl.sv - self-checking bench for score_table_ctrl with a cycle-level reference model
module tb_score_table_ctrl;
    import score_pkg::*;

    localparam int DW = 16;
    localparam int AW = 4;
    localparam int NE = 8;
    localparam int RL = 2;
`ifdef SCORE_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_id;
    logic [DW-1:0] cmd_data;
    logic [AW-1:0] ram_addr;
    logic          ram_wren;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_id;
    logic [DW-1:0] out_score;
    logic          out_last;
    logic          busy;
    logic          cmd_err;
    logic          sat_flag;

    score_table_ctrl #(.DATA_W(DW), .ADDR_W(AW), .NUM_ENTRIES(NE), .RD_LAT(RL)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_id(cmd_id), .cmd_data(cmd_data),
        .ram_addr(ram_addr), .ram_wren(ram_wren), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id),
        .out_score(out_score), .out_last(out_last),
        .busy(busy), .cmd_err(cmd_err), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] init_val(input int i);
        int v;
        v = (i == 7) ? 32'hFFF0 : (32'h0100 * i + 32'h0011);
        return v[DW-1:0];
    endfunction

    // Environment: single-port RAM with RL-cycle read pipeline
    logic [DW-1:0] ram [16];
    logic [AW-1:0] pipe [RL];
    bit            preload_done = 1'b0;

    always @(posedge clk) begin
        if (!preload_done) begin
            for (int i = 0; i < 16; i++) ram[i] <= init_val(i);
            preload_done <= 1'b1;
        end else if (ram_wren) begin
            ram[ram_addr] <= ram_wdata;
        end
        pipe[0] <= ram_addr;
        for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
    end
    assign ram_rdata = ram[pipe[RL-1]];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: expected behaviour derived from command timing rules
    typedef struct {
        int            wcyc;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        bit            s;
    } wr_t;

    wr_t           wq[$];
    logic [DW-1:0] mem_m [NE];
    bit            m_init = 1'b0;
    int            ready_at = 0;
    int            err_cyc = -10;
    bit            sat_m = 1'b0;
    bit            dump_active = 1'b0;
    int            dump_k = 0;
    int            valid_from = 0;
    int            acc_cyc = 0;

    int n_wr_seen = 0, n_err_seen = 0, n_hs_seen = 0, n_last_seen = 0, last_wr_cyc = 0;

    always @(negedge clk) begin
        int  c;
        bit  exp_ready, exp_wren, exp_valid;
        c = cyc;
        if (!m_init) begin
            for (int i = 0; i < NE; i++) mem_m[i] = init_val(i);
            m_init = 1'b1;
        end
        if (!rst) begin
            chk("rst_outs", {cmd_ready, busy, ram_wren, out_valid, out_last, cmd_err, sat_flag}, 7'd0);
            chk("rst_buses", {ram_addr, ram_wdata, out_id, out_score}, '0);
            wq.delete();
            ready_at    = 0;
            err_cyc     = -10;
            sat_m       = 1'b0;
            dump_active = 1'b0;
        end else begin
            exp_ready = !dump_active && (c >= ready_at);
            chk("cmd_ready", cmd_ready, exp_ready);
            chk("busy", busy, !exp_ready);
            chk("cmd_err", cmd_err, c == err_cyc);
            exp_wren = (wq.size() > 0) && (wq[0].wcyc == c);
            chk("ram_wren", ram_wren, exp_wren);
            if (exp_wren) begin
                chk("ram_addr", ram_addr, wq[0].a);
                chk("ram_wdata", ram_wdata, wq[0].d);
                mem_m[wq[0].a] = wq[0].d;
                if (wq[0].s) sat_m = 1'b1;
                void'(wq.pop_front());
            end
            chk("sat_flag", sat_flag, sat_m);
            exp_valid = dump_active && (c >= valid_from);
            chk("out_valid", out_valid, exp_valid);
            chk("out_last", out_last, exp_valid && (dump_k == NE - 1));
            if (exp_valid) begin
                chk("out_id", out_id, dump_k);
                chk("out_score", out_score, mem_m[dump_k]);
                if (out_ready) begin
                    if (dump_k == NE - 1) begin
                        dump_active = 1'b0;
                        ready_at    = c + 1;
                    end else begin
                        dump_k++;
                        valid_from = c + RL + 2;
                    end
                end
            end
            if (cmd_valid && exp_ready) begin
                acc_cyc = c;
                if ((cmd_op == OP_WRITE || cmd_op == OP_ADD) && int'(cmd_id) >= NE) begin
                    err_cyc = c + 1;
                end else if (cmd_op == OP_WRITE) begin
                    wq.push_back('{c + 1, cmd_id, cmd_data, 1'b0});
                    ready_at = c + 2;
                end else if (cmd_op == OP_ADD) begin
                    logic [DW:0] s;
                    s = {1'b0, mem_m[cmd_id]} + {1'b0, cmd_data};
                    wq.push_back('{c + RL + 2, cmd_id,
                                   (SAT && s[DW]) ? {DW{1'b1}} : s[DW-1:0], SAT && s[DW]});
                    ready_at = c + RL + 3;
                end else if (cmd_op == OP_DUMP) begin
                    dump_active = 1'b1;
                    dump_k      = 0;
                    valid_from  = c + RL + 2;
                end
            end
            if (ram_wren) begin
                n_wr_seen++;
                last_wr_cyc = c;
            end
            if (cmd_err) n_err_seen++;
            if (out_valid && out_ready) n_hs_seen++;
            if (out_valid && out_last) n_last_seen++;
        end
    end

    task automatic send(input logic [1:0] op, input int id, input logic [DW-1:0] d);
        int n;
        n = 0;
        while (!cmd_ready && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk("send_ready", cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_id    = id[AW-1:0];
        cmd_data  = d;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!cmd_ready && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk("idle_wait", cmd_ready, 1'b1);
    endtask

    initial begin
        int w0, e0, h0, l0, n;
        rst = 1'b0; cmd_valid = 1'b0; cmd_op = OP_NOP; cmd_id = '0; cmd_data = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;

        send(OP_WRITE, 5, 16'h1234);
        wait_idle();
        chk("lit_ram5_write", ram[5], 16'h1234);
        chk("lit_write_lat", last_wr_cyc - acc_cyc, 1);

        send(OP_ADD, 5, 16'h0010);
        wait_idle();
        chk("lit_ram5_add", ram[5], 16'h1244);
        chk("lit_model5", mem_m[5], 16'h1244);
        chk("lit_add_lat", last_wr_cyc - acc_cyc, 4);
        chk("lit_sat_after5", sat_flag, 1'b0);

        send(OP_ADD, 7, 16'h0020);
        wait_idle();
        chk("lit_ram7", ram[7], SAT ? 16'hFFFF : 16'h0010);
        chk("lit_sat7", sat_flag, SAT);

        w0 = n_wr_seen;
        e0 = n_err_seen;
        send(OP_NOP, 0, 16'h0);
        send(OP_WRITE, NE, 16'hDEAD);
        send(OP_ADD, 15, 16'h0001);
        repeat (3) @(posedge clk);
        #1;
        chk("lit_err_count", n_err_seen - e0, 2);
        chk("lit_no_wr_on_err", n_wr_seen - w0, 0);
        chk("lit_ready_after_err", cmd_ready, 1'b1);

        w0 = n_wr_seen;
        h0 = n_hs_seen;
        l0 = n_last_seen;
        send(OP_DUMP, 0, 16'h0);
        n = 0;
        while (!(cmd_ready && (n_hs_seen - h0 == NE)) && n < 400) begin
            @(posedge clk); #1;
            out_ready = ~out_ready;
            n++;
        end
        out_ready = 1'b0;
        chk("lit_dump_entries", n_hs_seen - h0, NE);
        chk("lit_dump_last", n_last_seen - l0 > 0, 1'b1);
        chk("lit_dump_no_wr", n_wr_seen - w0, 0);

        send(OP_DUMP, 0, 16'h0);
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("dump2_valid", out_valid, 1'b1);
        rst = 1'b0;
        #1;
        chk("lit_rst_valid", out_valid, 1'b0);
        chk("lit_rst_ready", cmd_ready, 1'b0);
        chk("lit_rst_busy", busy, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("lit_ready_post_rst", cmd_ready, 1'b1);
        @(posedge clk); #1;

        send(OP_WRITE, 3, 16'hBEEF);
        wait_idle();
        chk("lit_ram3", ram[3], 16'hBEEF);
        repeat (3) @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
